// File: rtl/cordic_pkg.sv
// Shared constants, mode encodings and tag type for the CORDIC arbiter.
package cordic_pkg;

    localparam int WORD_LENGTH     = 32;
    localparam int FRACTION_LENGTH = 22;
    localparam int ITERATION       = 13;
    localparam int PIPE_LATENCY    = 15;

    typedef enum logic [1:0] {
        MODE_VECTOR = 2'b00,
        MODE_SINCOS = 2'b01,
        MODE_ROT    = 2'b10,
        MODE_ROT_B  = 2'b11
    } cordic_mode_e;

    typedef struct packed {
        logic valid;
        logic id;
    } cordic_tag_t;

endpackage

// File: rtl/cordic_arbiter_if.sv
// Requester, CORDIC-core and response bundle of the two-port CORDIC arbiter.
interface cordic_arbiter_if #(
    parameter int W = cordic_pkg::WORD_LENGTH
);

    logic         i_cordic_arb_en;
    logic         i_req0_valid;
    logic         i_req1_valid;
    logic         o_req0_ready;
    logic         o_req1_ready;
    logic [1:0]   i_req0_mode;
    logic [1:0]   i_req1_mode;
    logic [W-1:0] i_req0_x;
    logic [W-1:0] i_req0_y;
    logic [W-1:0] i_req0_theta;
    logic [W-1:0] i_req1_x;
    logic [W-1:0] i_req1_y;
    logic [W-1:0] i_req1_theta;
    logic [1:0]   o_cordic_mode;
    logic [W-1:0] o_cordic_x;
    logic [W-1:0] o_cordic_y;
    logic [W-1:0] o_cordic_theta;
    logic [W-1:0] i_cordic_out1;
    logic [W-1:0] i_cordic_out2;
    logic         o_rsp0_valid;
    logic         o_rsp1_valid;
    logic [W-1:0] o_rsp_out1;
    logic [W-1:0] o_rsp_out2;
    logic         o_cordic_arb_busy;

    modport slave (
        input  i_cordic_arb_en,
        input  i_req0_valid, i_req1_valid,
        input  i_req0_mode, i_req1_mode,
        input  i_req0_x, i_req0_y, i_req0_theta,
        input  i_req1_x, i_req1_y, i_req1_theta,
        input  i_cordic_out1, i_cordic_out2,
        output o_req0_ready, o_req1_ready,
        output o_cordic_mode, o_cordic_x,
        output o_cordic_y, o_cordic_theta,
        output o_rsp0_valid, o_rsp1_valid,
        output o_rsp_out1, o_rsp_out2,
        output o_cordic_arb_busy
    );

    modport master (
        output i_cordic_arb_en,
        output i_req0_valid, i_req1_valid,
        output i_req0_mode, i_req1_mode,
        output i_req0_x, i_req0_y, i_req0_theta,
        output i_req1_x, i_req1_y, i_req1_theta,
        output i_cordic_out1, i_cordic_out2,
        input  o_req0_ready, o_req1_ready,
        input  o_cordic_mode, o_cordic_x,
        input  o_cordic_y, o_cordic_theta,
        input  o_rsp0_valid, o_rsp1_valid,
        input  o_rsp_out1, o_rsp_out2,
        input  o_cordic_arb_busy
    );

endinterface

// File: rtl/cordic_arb_tag_pipe.sv
// Tag delay line tracking which requester owns each in-flight CORDIC result.
module cordic_arb_tag_pipe
    import cordic_pkg::*;
#(
    parameter int DEPTH = PIPE_LATENCY
) (
    input  logic        clk,
    input  logic        rst_n,
    input  cordic_tag_t push_tag,
    output cordic_tag_t exit_tag,
    output logic        busy
);

    cordic_tag_t [DEPTH-1:0] stage_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                stage_q[i] <= stage_q[i-1];
            end
            stage_q[0] <= push_tag;
        end
    end

    assign exit_tag = stage_q[DEPTH-1];

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            busy = busy | stage_q[i].valid;
        end
    end

endmodule

// File: rtl/cordic_arbiter.sv
// Round-robin two-requester front end for a pipelined CORDIC core.
// Define CORDIC_ARB_PERF_EN to add saturating issue/conflict counters.
module cordic_arbiter #(
    parameter int WORD_LENGTH  = cordic_pkg::WORD_LENGTH,
    parameter int PIPE_LATENCY = cordic_pkg::PIPE_LATENCY
) (
    input  logic            i_cordic_arb_clk,
    input  logic            i_cordic_arb_rst_n,
    cordic_arbiter_if.slave arb
`ifdef CORDIC_ARB_PERF_EN
    ,
    output logic [31:0]     o_perf_issue0,
    output logic [31:0]     o_perf_issue1,
    output logic [31:0]     o_perf_conflict
`endif
);

    import cordic_pkg::*;

    logic                   clk;
    logic                   rst_n;
    logic                   en;
    logic                   rdy0;
    logic                   rdy1;
    logic                   acc;
    logic                   last_q;
    logic [1:0]             sel_mode;
    logic [WORD_LENGTH-1:0] sel_x;
    logic [WORD_LENGTH-1:0] sel_y;
    logic [WORD_LENGTH-1:0] sel_theta;
    logic [1:0]             mode_q;
    logic [WORD_LENGTH-1:0] x_q;
    logic [WORD_LENGTH-1:0] y_q;
    logic [WORD_LENGTH-1:0] theta_q;
    logic                   rsp0_q;
    logic                   rsp1_q;
    logic [WORD_LENGTH-1:0] out1_q;
    logic [WORD_LENGTH-1:0] out2_q;
    cordic_tag_t            push_tag;
    cordic_tag_t            exit_tag;
    logic                   busy;

    assign clk   = i_cordic_arb_clk;
    assign rst_n = i_cordic_arb_rst_n;
    assign en    = arb.i_cordic_arb_en;

    // last_q holds the id granted most recently; the other side wins a tie
    always_comb begin
        rdy0 = en & arb.i_req0_valid & (~arb.i_req1_valid | last_q);
        rdy1 = en & arb.i_req1_valid & (~arb.i_req0_valid | ~last_q);
    end

    assign acc = rdy0 | rdy1;

    always_comb begin
        sel_mode  = arb.i_req0_mode;
        sel_x     = arb.i_req0_x;
        sel_y     = arb.i_req0_y;
        sel_theta = arb.i_req0_theta;
        unique case (1'b1)
            rdy0: begin
                sel_mode  = arb.i_req0_mode;
                sel_x     = arb.i_req0_x;
                sel_y     = arb.i_req0_y;
                sel_theta = arb.i_req0_theta;
            end
            rdy1: begin
                sel_mode  = arb.i_req1_mode;
                sel_x     = arb.i_req1_x;
                sel_y     = arb.i_req1_y;
                sel_theta = arb.i_req1_theta;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q  <= 1'b1;
            mode_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            theta_q <= '0;
        end else if (acc) begin
            last_q  <= rdy1;
            mode_q  <= sel_mode;
            x_q     <= sel_x;
            y_q     <= sel_y;
            theta_q <= sel_theta;
        end
    end

    always_comb begin
        push_tag.valid = acc;
        push_tag.id    = rdy1;
    end

    cordic_arb_tag_pipe #(
        .DEPTH    (PIPE_LATENCY)
    ) u_tag_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_tag (push_tag),
        .exit_tag (exit_tag),
        .busy     (busy)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp0_q <= 1'b0;
            rsp1_q <= 1'b0;
            out1_q <= '0;
            out2_q <= '0;
        end else begin
            rsp0_q <= exit_tag.valid & ~exit_tag.id;
            rsp1_q <= exit_tag.valid & exit_tag.id;
            if (exit_tag.valid) begin
                out1_q <= arb.i_cordic_out1;
                out2_q <= arb.i_cordic_out2;
            end
        end
    end

    assign arb.o_req0_ready      = rdy0;
    assign arb.o_req1_ready      = rdy1;
    assign arb.o_cordic_mode     = mode_q;
    assign arb.o_cordic_x        = x_q;
    assign arb.o_cordic_y        = y_q;
    assign arb.o_cordic_theta    = theta_q;
    assign arb.o_rsp0_valid      = rsp0_q;
    assign arb.o_rsp1_valid      = rsp1_q;
    assign arb.o_rsp_out1        = out1_q;
    assign arb.o_rsp_out2        = out2_q;
    assign arb.o_cordic_arb_busy = busy;

`ifdef CORDIC_ARB_PERF_EN
    logic [31:0] issue0_q;
    logic [31:0] issue1_q;
    logic [31:0] conflict_q;
    logic        conflict;

    assign conflict = en & arb.i_req0_valid & arb.i_req1_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issue0_q   <= '0;
            issue1_q   <= '0;
            conflict_q <= '0;
        end else begin
            if (rdy0 && issue0_q != '1) issue0_q <= issue0_q + 32'd1;
            if (rdy1 && issue1_q != '1) issue1_q <= issue1_q + 32'd1;
            if (conflict && conflict_q != '1) conflict_q <= conflict_q + 32'd1;
        end
    end

    assign o_perf_issue0   = issue0_q;
    assign o_perf_issue1   = issue1_q;
    assign o_perf_conflict = conflict_q;
`endif

endmodule
